// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   ZW : dividend (product) width
//   YW : divisor width, also the remainder width
//   QW : saturated output quotient width
//   CW : step counter width
//   div_state_t : controller states
package div_pkg;

  localparam int ZW = 16;
  localparam int YW = 8;
  localparam int QW = 8;
  localparam int CW = $clog2(ZW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_in  : partial remainder before the step (YW+1 bits, always < divisor)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor
//   rem_out : partial remainder after the step (YW+1 bits)
//   q_out   : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int W = YW
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_out
);

  logic [W+1:0] rem_shift;
  logic [W:0]   diff;

  // rem_in < divisor, so the shifted value is below 2*divisor and fits in W+1
  // bits; the extra top bit only keeps the compare exact.
  assign rem_shift = {rem_in, bit_in};
  assign q_out     = (rem_shift >= {2'b00, divisor});
  assign diff      = rem_shift[W:0] - {1'b0, divisor};
  assign rem_out   = q_out ? diff : rem_shift[W:0];

endmodule

// File: rtl/unsigned_divider_16x8_seq.sv
// Sequential unsigned restoring divider: x = z / y, r = z % y, one quotient bit
// per clock, valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (z dividend, y divisor)
//   out_valid/out_ready : result handshake; results held while out_valid is high
//   x   : quotient, saturated to all ones on ovf or dz
//   r   : remainder
//   ovf : true quotient does not fit in QW bits
//   dz  : divisor was zero
module unsigned_divider_16x8_seq
  import div_pkg::*;
#(
  parameter int ZW = div_pkg::ZW,
  parameter int YW = div_pkg::YW,
  parameter int QW = div_pkg::QW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [ZW-1:0] z,
  input  logic [YW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] x,
  output logic [YW-1:0] r,
  output logic          ovf,
  output logic          dz
);

  localparam int CNT_W = $clog2(ZW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ZW - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Combined dividend/quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom, so after ZW steps it holds the
  // full ZW-bit quotient.
  logic [ZW-1:0]    dq_q, dq_d;
  logic [YW-1:0]    y_q, y_d;
  logic [YW:0]      rem_q, rem_d;
  logic [QW-1:0]    x_q, x_d;
  logic [YW-1:0]    r_q, r_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [YW:0]      step_rem;
  logic             step_q;

  div_step #(.W(YW)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dq_q[ZW-1]),
    .divisor (y_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dq_d    = dq_q;
    y_d     = y_q;
    rem_d   = rem_q;
    x_d     = x_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dq_d    = z;
          y_d     = y;
          rem_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        dq_d  = {dq_q[ZW-2:0], step_q};
        rem_d = step_rem;
        if (count_q == LAST) begin
          state_d = DONE;
          if (y_q == '0) begin
            // Arithmetic result is meaningless for a zero divisor.
            x_d   = '1;
            r_d   = '0;
            ovf_d = 1'b0;
            dz_d  = 1'b1;
          end else begin
            ovf_d = |dq_d[ZW-1:QW];
            x_d   = ovf_d ? {QW{1'b1}} : dq_d[QW-1:0];
            r_d   = step_rem[YW-1:0];
            dz_d  = 1'b0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      dq_q    <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      x_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dq_q    <= dq_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x         = x_q;
  assign r         = r_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_unsigned_divider_16x8_seq.sv
module tb_unsigned_divider_16x8_seq;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] r;
    logic       ovf;
    logic       dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] z = '0;
  logic [7:0]  y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  x;
  logic [7:0]  r;
  logic        ovf;
  logic        dz;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  res_t exp_q[$];

  unsigned_divider_16x8_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .r(r), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [15:0] zz, input logic [7:0] yy);
    res_t m;
    int   q;
    if (yy == 8'd0) begin
      m.x = 8'hFF; m.r = 8'd0; m.ovf = 1'b0; m.dz = 1'b1;
    end else begin
      q     = int'(zz) / int'(yy);
      m.r   = 8'(int'(zz) % int'(yy));
      m.dz  = 1'b0;
      m.ovf = (q > 255);
      m.x   = m.ovf ? 8'hFF : 8'(q);
    end
    return m;
  endfunction

  function automatic res_t observed();
    res_t o;
    o.x = x; o.r = r; o.ovf = ovf; o.dz = dz;
    return o;
  endfunction

  // Present one operand pair in IDLE; returns #1 after the accepting edge.
  task automatic start_op(input logic [15:0] zz, input logic [7:0] yy, input bit push);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    z = zz; y = yy; in_valid = 1'b1;
    if (push) exp_q.push_back(model(zz, yy));
    $display("drive z=%0d y=%0d", zz, yy);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen, bounded.
  task automatic wait_out(output int lat, output bit to);
    lat = 0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; lat++;
      if (out_valid) begin to = 1'b0; break; end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 18'd0}) begin
      n_fail++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b x=%0d r=%0d ovf=%0b dz=%0b, want 1 0 0 0 0 0",
               in_ready, out_valid, x, r, ovf, dz);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string name, input logic [15:0] zz, input logic [7:0] yy);
    int   lat;
    bit   to;
    res_t e, o;
    start_op(zz, yy, 1'b1);
    wait_out(lat, to);
    n_checks++;
    if (to || lat != 16) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles (timeout=%0b), want 16", name, lat, to);
    end
    e = exp_q.pop_front();
    o = observed();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s: got x=%0d r=%0d ovf=%0b dz=%0b, want x=%0d r=%0d ovf=%0b dz=%0b",
               name, o.x, o.r, o.ovf, o.dz, e.x, e.r, e.ovf, e.dz);
    end
    $display("result %s z=%0d y=%0d x=%0d r=%0d ovf=%0b dz=%0b lat=%0d", name, zz, yy, o.x, o.r, o.ovf, o.dz, lat);
    release_out();
  endtask

  task automatic test_stall();
    int   lat;
    bit   to;
    res_t e;
    start_op(16'd5000, 8'd13, 1'b1);
    wait_out(lat, to);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin z = 16'd5; y = 8'd1; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, e}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: out_valid=%0b in_ready=%0b x=%0d r=%0d, want 1 0 x=%0d r=%0d",
                 i, out_valid, in_ready, x, r, e.x, e.r);
      end
    end
    $display("result stall x=%0d r=%0d held 5 cycles", x, r);
    release_out();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release: out_valid=%0b in_ready=%0b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_ghost_op: in_ready=%0b, want 1", in_ready);
    end
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    start_op(16'd1000, 8'd7, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 18'd0}) begin
      n_fail++;
      $display("FAIL abort_reset: in_ready=%0b out_valid=%0b x=%0d r=%0d, want 1 0 0 0",
               in_ready, out_valid, x, r);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid rose=%0b, want 0", seen);
    end
    $display("result abort out_valid_seen=%0b", seen);
    test_single("after_abort", 16'd100, 8'd10);
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [15:0] zs[N];
    logic [7:0]  ys[N];
    zs[0] = 16'hFE01; ys[0] = 8'hFF;
    zs[1] = 16'hFFFF; ys[1] = 8'd1;
    zs[2] = 16'd777;  ys[2] = 8'd0;
    for (int i = 3; i < N; i++) begin
      zs[i] = 16'($urandom);
      ys[i] = 8'($urandom_range(1, 255));
    end
    out_ready = 1'b1;
    fork
      begin : producer
        int prev = 0;
        for (int i = 0; i < N; i++) begin
          int g = 0;
          z = zs[i]; y = ys[i]; in_valid = 1'b1;
          while (!in_ready && g < 60) begin
            @(posedge clk); #1; g++;
          end
          exp_q.push_back(model(zs[i], ys[i]));
          $display("drive z=%0d y=%0d", zs[i], ys[i]);
          @(posedge clk); #1;
          if (i > 0) begin
            n_checks++;
            if (cyc - prev != 18) begin
              n_fail++;
              $display("FAIL throughput[%0d]: accept interval %0d, want 18", i, cyc - prev);
            end
          end
          prev = cyc;
        end
        in_valid = 1'b0;
      end
      begin : consumer
        for (int i = 0; i < N; i++) begin
          int   g = 0;
          res_t e, o;
          while (!out_valid && g < 60) begin
            @(posedge clk); #1; g++;
          end
          n_checks++;
          if (!out_valid) begin
            n_fail++;
            $display("FAIL b2b_timeout[%0d]: out_valid=0, want 1", i);
          end else begin
            e = exp_q.pop_front();
            o = observed();
            if (o !== e) begin
              n_fail++;
              $display("FAIL b2b[%0d]: got x=%0d r=%0d ovf=%0b dz=%0b, want x=%0d r=%0d ovf=%0b dz=%0b",
                       i, o.x, o.r, o.ovf, o.dz, e.x, e.r, e.ovf, e.dz);
            end
            $display("result b2b[%0d] x=%0d r=%0d ovf=%0b dz=%0b", i, o.x, o.r, o.ovf, o.dz);
            @(posedge clk); #1;
          end
        end
      end
    join
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single("basic_1000_7", 16'd1000, 8'd7);
    test_single("exact_inverse", 16'hFE01, 8'hFF);
    test_single("overflow", 16'hFFFF, 8'hFF);
    test_single("div_zero", 16'h1234, 8'd0);
    test_stall();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
